// File: rtl/roi_window_ctrl.sv
// roi_window_ctrl: staged ROI windows with frame-boundary commit and registered per-pixel hit flag/index.
module roi_window_ctrl #(
  parameter int          NWIN   = 4,
  parameter logic [10:0] DEF_X1 = 11'd180,
  parameter logic [10:0] DEF_X2 = 11'd330,
  parameter logic [9:0]  DEF_Y1 = 10'd10,
  parameter logic [9:0]  DEF_Y2 = 10'd110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [10:0] pix_x,
  input  logic [9:0]  pix_y,
  input  logic        frame_start,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_idx,
  input  logic [10:0] cfg_x1,
  input  logic [10:0] cfg_x2,
  input  logic [9:0]  cfg_y1,
  input  logic [9:0]  cfg_y2,
  input  logic        cfg_wen,
  output logic        cfg_err,
  input  logic        commit_req,
  output logic        commit_done,
  output logic        outg,
  output logic [1:0]  out_idx
);
  typedef struct packed {
    logic [10:0] x1;
    logic [10:0] x2;
    logic [9:0]  y1;
    logic [9:0]  y2;
    logic        wen;
  } win_t;
  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
  localparam win_t DEF_W = {DEF_X1, DEF_X2, DEF_Y1, DEF_Y2, 1'b1};
  win_t stg_q [NWIN];
  win_t act_q [NWIN];
  state_t state_q, state_d;
  logic err_q, outg_q, outg_d, hit_any, xfer, bad;
  logic [1:0] idx_q, idx_d, hit_idx;
  assign cfg_ready   = state_q == IDLE && !reset;
  assign xfer        = cfg_valid && cfg_ready;
  assign bad         = cfg_wen && (cfg_x1 > cfg_x2 || cfg_y1 > cfg_y2);
  assign commit_done = state_q == DONE;
  assign cfg_err     = err_q;
  assign outg        = outg_q;
  assign out_idx     = idx_q;
  always_comb begin
    state_d = state_q == IDLE ? (commit_req ? PEND : IDLE) :
              state_q == PEND ? (frame_start ? DONE : PEND) : IDLE;
  end
  // Scan high to low so the lowest-numbered hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NWIN - 1; i >= 0; i--)
      if (act_q[i].wen && act_q[i].x1 <= pix_x && pix_x <= act_q[i].x2 &&
          act_q[i].y1 <= pix_y && pix_y <= act_q[i].y2) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
    outg_d = en && hit_any;
    idx_d  = outg_d ? hit_idx : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      outg_q  <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < NWIN; i++) begin
        stg_q[i] <= i == 0 ? DEF_W : '0;
        act_q[i] <= i == 0 ? DEF_W : '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= xfer && bad;
      outg_q  <= outg_d;
      idx_q   <= idx_d;
      if (xfer && !bad) stg_q[cfg_idx] <= {cfg_x1, cfg_x2, cfg_y1, cfg_y2, cfg_wen};
      // Pixel in the frame_start cycle still sees the old set; the copy lands at this edge.
      if (state_q == PEND && frame_start) act_q <= stg_q;
    end
  end
endmodule

// File: tb/tb_roi_window_ctrl.sv
// tb_roi_window_ctrl: directed self-checking bench for roi_window_ctrl.
module tb_roi_window_ctrl;
  logic        clk = 0, reset = 1, en = 0, frame_start = 0, cfg_valid = 0, cfg_wen = 0, commit_req = 0;
  logic [10:0] pix_x = 0, cfg_x1 = 0, cfg_x2 = 0;
  logic [9:0]  pix_y = 0, cfg_y1 = 0, cfg_y2 = 0;
  logic [1:0]  cfg_idx = 0, out_idx;
  logic        cfg_ready, cfg_err, commit_done, outg;
  int n_chk = 0, n_fail = 0;

  roi_window_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_x1(cfg_x1), .cfg_x2(cfg_x2),
    .cfg_y1(cfg_y1), .cfg_y2(cfg_y2), .cfg_wen(cfg_wen), .cfg_err(cfg_err), .commit_req(commit_req),
    .commit_done(commit_done), .outg(outg), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y);
    pix_x = 11'(x);
    pix_y = 10'(y);
  endtask

  task automatic ov(input string tag, input int x, input int y, input logic eg, input logic [1:0] ei);
    pix(x, y);
    step();
    chk({tag, "_outg"}, outg, eg);
    chk({tag, "_idx"}, out_idx, ei);
  endtask

  task automatic wr(input logic [1:0] i, input int x1, input int x2, input int y1, input int y2,
                    input logic w, input logic eerr);
    cfg_idx = i; cfg_x1 = 11'(x1); cfg_x2 = 11'(x2); cfg_y1 = 10'(y1); cfg_y2 = 10'(y2); cfg_wen = w;
    cfg_valid = 1;
    step();
    cfg_valid = 0;
    chk("wr_err", cfg_err, eerr);
  endtask

  task automatic commit();
    commit_req = 1;
    step();
    commit_req = 0;
    chk("cm_pend_ready", cfg_ready, 0);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("cm_done", commit_done, 1);
    step();
    chk("cm_done_low", commit_done, 0);
    chk("cm_ready_back", cfg_ready, 1);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready_low", cfg_ready, 0);
    chk("rst_outg", outg, 0);
    chk("rst_done", commit_done, 0);
    reset = 0;
    en = 1;
    #1;
    chk("rel_ready", cfg_ready, 1);
    ov("s179", 179, 10, 0, 0);
    chk("rel_err", cfg_err, 0);
    chk("rel_done", commit_done, 0);
    ov("s180", 180, 10, 1, 0);
    ov("s330", 330, 110, 1, 0);
    ov("s331", 331, 110, 0, 0);
    ov("s200", 200, 111, 0, 0);

    wr(1, 0, 50, 0, 50, 1, 0);
    pix(10, 10);
    commit_req = 1;
    step();
    commit_req = 0;
    chk("w1_pend_ready", cfg_ready, 0);
    chk("w1_pre_outg", outg, 0);
    step();
    chk("w1_pend_outg", outg, 0);
    chk("w1_no_done", commit_done, 0);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("w1_done", commit_done, 1);
    chk("w1_fs_old_set", outg, 0);
    step();
    chk("w1_new_outg", outg, 1);
    chk("w1_new_idx", out_idx, 1);
    chk("w1_ready", cfg_ready, 1);

    wr(2, 190, 250, 40, 60, 1, 0);
    ov("ovl0", 200, 50, 1, 0);
    wr(0, 0, 0, 0, 0, 0, 0);
    commit_req = 1;
    frame_start = 1;
    step();
    commit_req = 0;
    chk("same_cyc_no_done", commit_done, 0);
    chk("same_cyc_old_idx", out_idx, 0);
    step();
    frame_start = 0;
    chk("turn_done", commit_done, 1);
    chk("turn_old_idx", out_idx, 0);
    step();
    chk("ovl2_outg", outg, 1);
    chk("ovl2_idx", out_idx, 2);

    wr(3, 100, 50, 0, 100, 1, 1);
    step();
    chk("err_pulse_end", cfg_err, 0);
    pix(75, 50);
    commit();
    chk("inv_w3_outg", outg, 0);
    chk("inv_w3_idx", out_idx, 0);

    commit_req = 1;
    step();
    commit_req = 0;
    cfg_idx = 3; cfg_x1 = 70; cfg_x2 = 80; cfg_y1 = 40; cfg_y2 = 60; cfg_wen = 1;
    cfg_valid = 1;
    step();
    chk("hold_ready0", cfg_ready, 0);
    step();
    frame_start = 1;
    step();
    frame_start = 0;
    chk("hold_done", commit_done, 1);
    chk("hold_ready_done", cfg_ready, 0);
    step();
    chk("hold_ready_idle", cfg_ready, 1);
    chk("hold_no_early", outg, 0);
    step();
    cfg_valid = 0;
    chk("hold_err", cfg_err, 0);
    commit();
    chk("hold_w3_outg", outg, 1);
    chk("hold_w3_idx", out_idx, 3);

    commit_req = 1;
    step();
    commit_req = 0;
    reset = 1;
    #1;
    chk("rp_ready_low", cfg_ready, 0);
    step();
    chk("rp_outg", outg, 0);
    chk("rp_idx", out_idx, 0);
    chk("rp_done", commit_done, 0);
    reset = 0;
    frame_start = 1;
    ov("rp180", 180, 10, 1, 0);
    frame_start = 0;
    chk("rp_no_done", commit_done, 0);
    chk("rp_ready", cfg_ready, 1);
    ov("rp330", 330, 110, 1, 0);
    ov("rp331", 331, 110, 0, 0);
    ov("rp_w3", 75, 50, 0, 0);

    en = 0;
    ov("en0", 200, 50, 0, 0);
    wr(1, 0, 50, 0, 50, 1, 0);
    commit();
    chk("en0_outg", outg, 0);
    chk("en0_idx", out_idx, 0);
    en = 1;
    ov("en1_w1", 10, 10, 1, 1);
    ov("en1_w0", 200, 50, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/roi_window_ctrl.md
# roi_window_ctrl

Configures and sequences the rectangular region-of-interest overlays on the video path. The block holds up to four counting windows in staging registers that a host writes through a valid/ready handshake, and commits them atomically at a frame boundary so no frame is drawn with a half-updated window set. Every pixel cycle it outputs the overlay flag and the index of the window hit. It sits between the pixel-coordinate generator and the VGA colour mux.

## Interface
- NWIN, 4: number of windows (index width 2; fixed for this revision).
- DEF_X1, 11'd180: reset x1 of window 0.
- DEF_X2, 11'd330: reset x2 of window 0.
- DEF_Y1, 10'd10: reset y1 of window 0.
- DEF_Y2, 10'd110: reset y2 of window 0.

- clk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  overlay enable; gates outg only.
- pix_x  in  11  current pixel column.
- pix_y  in  10  current pixel row.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- cfg_valid  in  1  host write request.
- cfg_ready  out  1  block accepts a write this cycle.
- cfg_idx  in  2  target window.
- cfg_x1, cfg_x2  in  11  column bounds, inclusive.
- cfg_y1, cfg_y2  in  10  row bounds, inclusive.
- cfg_wen  in  1  window enable written with the bounds.
- cfg_err  out  1  one-cycle pulse: accepted write rejected as invalid.
- commit_req  in  1  request to apply staged windows at the next frame_start.
- commit_done  out  1  one-cycle pulse: active set updated.
- outg  out  1  registered overlay flag.
- out_idx  out  2  registered index of the lowest-numbered window hit; 0 when none.

## Operation
- Two banks of NWIN entries {x1,x2,y1,y2,wen}: staging and active. Reset: both banks hold window 0 = DEF_* with wen=1; windows 1..3 zero bounds with wen=0.
- Write handshake: transfer when cfg_valid && cfg_ready on a rising edge. cfg_ready is 1 only in IDLE. The host holds cfg_* stable until the transfer.
- Validation: if cfg_x1 > cfg_x2 or cfg_y1 > cfg_y2, the transfer completes, staging is unchanged, and cfg_err=1 on the next cycle. Otherwise staging[cfg_idx] is written. cfg_wen=0 is always valid.
- FSM with states IDLE, PEND, DONE:
  - IDLE: if commit_req, go to PEND. A write accepted in the same cycle lands in staging before the commit.
  - PEND: cfg_ready=0. On the edge where frame_start=1, copy active <= staging for all entries and go to DONE. frame_start in the same cycle as the IDLE->PEND transition does not commit; the next frame_start does.
  - DONE: commit_done=1 for one cycle, then go to IDLE.
  - commit_req is ignored in PEND and DONE.
- Commit happens regardless of en.
- Hit test per window i: active.wen && x1<=pix_x<=x2 && y1<=pix_y<=y2, unsigned and inclusive. The lowest index hit wins out_idx.
- outg = en && any hit. When en=0, outg=0 and out_idx=0.
- Reset mid-operation, including in PEND: FSM goes to IDLE, both banks reload their reset values, and all outputs go to their reset values.

## Timing
- Reset values: outg=0, out_idx=0, cfg_err=0, commit_done=0, cfg_ready=1 on the first cycle after reset is released (0 while reset is high).
- Overlay latency is 1 cycle: outg/out_idx at edge t+1 reflect pix_x/pix_y/en at edge t.
- Commit boundary: the pixel sampled in the frame_start cycle is tested against the old active set. Pixels from the following cycle onward use the new set.
- commit_done rises the cycle after the frame_start edge. cfg_ready returns 1 the cycle after that.
- cfg_err rises the cycle after the rejected transfer.
- Minimum commit turnaround: 3 cycles from commit_req, if frame_start arrives in the cycle after commit_req.

## Test plan
- Reset, no writes, en=1. Scan pix (179,10), (180,10), (330,110), (331,110), (200,111) -> outg = 0,1,1,0,0 one cycle later; out_idx=0 throughout.
- Write window 1 = (0,50,0,50,wen=1), assert commit_req, then pulse frame_start. Before the pulse, pix (10,10) -> outg=0. After commit_done, pix (10,10) -> outg=1, out_idx=1.
- Overlap: window 0 and window 2 both cover (200,50) -> out_idx=0. Disable window 0 and commit -> out_idx=2.
- Invalid write idx=3, x1=100, x2=50 -> cfg_err pulse one cycle later; after commit, window 3 stays disabled and no hit at x=75.
- In PEND, cfg_ready=0 and cfg_valid held high -> no transfer until IDLE. Assert reset in PEND -> state IDLE, window 0 back at 180/330/10/110, no commit_done.
- en=0 while inside window 0 -> outg=0 and out_idx=0. A commit in that period still completes and commit_done pulses.
